// File: rtl/onoff_rr_arbiter.sv
// Round-robin arbiter for one shared on/off resource.
// Enforces minimum hold, maximum hold under contention and a guard gap,
// and emits one-cycle JK pulses (res_j on grant, res_k after release).
module onoff_rr_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned MIN_ON = 2,
  parameter int unsigned MAX_ON = 8,
  parameter int unsigned GAP    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 res_j,
  output logic                 res_k
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_ON + 1);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [OW-1:0] ptr, ptr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [N-1:0]  gnt_d;
  logic [OW-1:0] owner_d;
  logic          busy_d, res_j_d, res_k_d;

  logic [OW-1:0] win;
  logic          win_vld;
  logic          rel;
  logic [OW-1:0] ptr_next;

  // Winner search: first set request at or above ptr, wrapping N-1 -> 0.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!win_vld && req[OW'((int'(ptr) + i) % int'(N))]) begin
        win     = OW'((int'(ptr) + i) % int'(N));
        win_vld = 1'b1;
      end
    end
  end

  // Release: owner done after minimum hold, or pre-empted at maximum hold.
  always_comb begin
    rel = 1'b0;
    if (cnt >= CW'(MIN_ON) && !req[owner]) rel = 1'b1;
    if (cnt >= CW'(MAX_ON) && (|(req & ~gnt))) rel = 1'b1;
    ptr_next = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    gcnt_d  = gcnt;
    gnt_d   = gnt;
    owner_d = owner;
    busy_d  = busy;
    res_j_d = 1'b0;
    res_k_d = 1'b0;
    case (state)
      S_IDLE: begin
        // The res_k cycle is never an arbitration cycle, even with no gap.
        if (win_vld && !res_k) begin
          state_d = S_ON;
          gnt_d   = N'(1) << win;
          owner_d = win;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
          res_j_d = 1'b1;
        end
      end
      S_ON: begin
        if (rel) begin
          gnt_d   = '0;
          res_k_d = 1'b1;
          ptr_d   = ptr_next;
          cnt_d   = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = GW'(GAP);
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else if (cnt < CW'(MAX_ON)) begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_GAP: begin
        // First cycle carries res_k, then GAP idle-guard cycles follow.
        if (gcnt == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gcnt  <= '0;
      gnt   <= '0;
      owner <= '0;
      busy  <= 1'b0;
      res_j <= 1'b0;
      res_k <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      gcnt  <= gcnt_d;
      gnt   <= gnt_d;
      owner <= owner_d;
      busy  <= busy_d;
      res_j <= res_j_d;
      res_k <= res_k_d;
    end
  end

endmodule

// File: doc/onoff_rr_arbiter.md
# onoff_rr_arbiter

Round-robin arbiter that shares one on/off resource among N requesters. It owns the grant state machine and enforces a minimum hold time, a maximum hold time under contention, and a guard gap between owners. It emits one-cycle turn-on (`res_j`) and turn-off (`res_k`) pulses that drive the `j`/`k` inputs of a JK-style on/off state machine.

## Interface
- `N`, default 4: number of requesters; must be ≥2.
- `MIN_ON`, default 2: minimum grant length in cycles; must be ≥1.
- `MAX_ON`, default 8: grant length after which the owner is pre-empted if another requester is waiting; must be ≥`MIN_ON`.
- `GAP`, default 1: forced idle cycles between a release and the next arbitration; must be ≥0.

- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `req`, in, N: level request per requester.
- `gnt`, out, N: one-hot grant, or all zero; registered.
- `owner`, out, clog2(N): index of the current or most recent owner; registered.
- `busy`, out, 1: high whenever state ≠ IDLE; registered.
- `res_j`, out, 1: one-cycle pulse in the first cycle of every grant.
- `res_k`, out, 1: one-cycle pulse in the first cycle after every release.

## Operation
- States:
  - IDLE: no grant.
  - ON: grant active.
  - GAP: guard interval.
- Registers:
  - `ptr`: round-robin start index, clog2(N) bits.
  - `cnt`: clog2(MAX_ON+1) bits, saturating at MAX_ON.
  - `gcnt`: gap counter.
- IDLE:
  - If `req` ≠ 0, the winner is the first set bit searching upward from `ptr`, wrapping N-1→0.
  - Next edge: enter ON, `gnt`=onehot(winner), `owner`=winner, `cnt`=1, `res_j`=1.
  - If `req` = 0, remain in IDLE.
- ON:
  - Each cycle `cnt` increments, saturating at MAX_ON.
  - Release is required when either condition holds:
    - (a) `cnt` ≥ MIN_ON and `req[owner]`=0;
    - (b) `cnt` ≥ MAX_ON and any other `req` bit is set.
  - Release edge:
    - `gnt`=0, `res_k`=1, `ptr`=(owner+1) mod N.
    - Next state is GAP if GAP>0, else IDLE.
  - If `cnt` ≥ MAX_ON and no other request is pending, the owner keeps the grant indefinitely. `cnt` stays at MAX_ON.
- GAP:
  - Lasts exactly GAP cycles, then IDLE.
  - `req` is ignored for arbitration during GAP.
- `owner` holds its value after release. `gnt` is always zero outside ON.
- `res_j` and `res_k` are never high in the same cycle. There is exactly one `res_j` and one `res_k` per completed grant.
- The owner dropping `req` before MIN_ON does not shorten the grant.
- Other requesters' `req` changes during ON have no effect except through condition (b).

## Timing
- Reset values (asynchronous, on `resetn`=0): state=IDLE, `gnt`=0, `owner`=0, `busy`=0, `res_j`=0, `res_k`=0, `ptr`=0, `cnt`=0, `gcnt`=0.
- Reset mid-grant: all outputs drop immediately. No `res_k` is emitted; the downstream resource is reset by its own reset.
- First rising edge with `resetn`=1 operates normally.
- Grant latency: a request seen in an IDLE cycle is granted at the next edge (1 cycle).
- Grant length:
  - Minimum: MIN_ON cycles.
  - Under contention: exactly MAX_ON cycles.
  - Otherwise: until the first cycle with `cnt` ≥ MIN_ON and the owner's `req` low, plus 0 cycles (release takes effect at that edge).
- Owner-to-next-owner turnaround: 1 (res_k) + GAP + 1 (IDLE arbitration) cycles from the release edge to the next `gnt`.
  - With GAP=0: next `gnt` rises 2 edges after the release edge.
- `res_j` is coincident with the first `gnt` cycle. `res_k` is coincident with the first `gnt`=0 cycle.
- `busy` rises with `gnt` and falls on entry to IDLE.

## Test plan
- Reset and single request:
  - Stimulus: `resetn` low, then high; `req`=0001 held for 5 cycles, then 0000. Defaults.
  - Required: `gnt`=0001 from the edge after `req` seen; `res_j` pulses once; `gnt` stays high while `req` is high.
  - After `req` drops: `gnt` falls one edge later, `res_k` pulses once, `busy` drops after 1 GAP cycle.
- Minimum hold:
  - Stimulus: `req`=0100 for 1 cycle only (MIN_ON=2).
  - Required: `gnt`=0100 for exactly 2 cycles, `owner`=2, then `res_k`.
- Pre-emption:
  - Stimulus: `req`=0011 held continuously.
  - Required: requester 0 granted for exactly 8 cycles, then `res_k`, 1 GAP cycle, 1 IDLE cycle, then requester 1 granted for 8 cycles; grants alternate 0,1,0,1.
- Round-robin wrap:
  - Stimulus: `req`=1111 held continuously.
  - Required: owner sequence 0,1,2,3,0; each grant 8 cycles; `ptr` wraps 3→0.
- Uncontended saturation:
  - Stimulus: `req`=1000 held for 20 cycles.
  - Required: a single continuous grant of 20 cycles with no pre-emption; `cnt` stays at 8.
- Asynchronous reset mid-grant:
  - Stimulus: `resetn` pulled low between edges during a grant to requester 2.
  - Required: `gnt`, `busy`, `res_j`, `res_k` go to 0 immediately with no `res_k` pulse.
  - After release of reset with `req`=0100: requester 2 is granted first (`ptr`=0 search finds bit 2).
